// File: rtl/rv_scoreboard_mc.sv
// Per-warp register hazard tracker: pending-write counters per (warp, register),
// multi-channel writeback release, configurable WAW policy and sticky underflow flag.
module rv_scoreboard_mc #(
  parameter int NUM_WARPS    = 4,
  parameter int NW_BITS      = 2,
  parameter int NUM_REGS     = 64,
  parameter int NR_BITS      = 6,
  parameter int NUM_WB       = 2,
  parameter int CNT_BITS     = 2,
  parameter int WAW_STALL    = 1,
  parameter int R0_HARDWIRED = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ibuffer_if_valid,
  input  logic [NW_BITS-1:0]         ibuffer_if_wid,
  input  logic                       ibuffer_if_wb,
  input  logic [NR_BITS-1:0]         ibuffer_if_rd,
  input  logic [NR_BITS-1:0]         ibuffer_if_rs1,
  input  logic [NR_BITS-1:0]         ibuffer_if_rs2,
  input  logic [NR_BITS-1:0]         ibuffer_if_rs3,
  output logic                       ibuffer_if_ready,
  input  logic [NUM_WB-1:0]          writeback_if_valid,
  input  logic [NUM_WB*NW_BITS-1:0]  writeback_if_wid,
  input  logic [NUM_WB*NR_BITS-1:0]  writeback_if_rd,
  input  logic [NUM_WB-1:0]          writeback_if_eop,
  output logic [NUM_WB-1:0]          writeback_if_ready,
  output logic [NUM_WARPS-1:0]       warp_busy,
  output logic                       underflow_err
);

  localparam logic [CNT_BITS-1:0] CMAX = '1;
  // Headroom for cnt + inc and the per-entry release count.
  localparam int EW = CNT_BITS + 8;

  logic [CNT_BITS-1:0]           cnt_q [NUM_WARPS][NUM_REGS];
  logic [CNT_BITS-1:0]           cnt_d [NUM_WARPS][NUM_REGS];
  logic [NUM_WARPS*NUM_REGS-1:0] uf_vec;
  logic                          underflow_q;

  logic                          reserve;
  logic                          rd_live;
  logic                          raw_block;
  logic                          waw_block;
  logic [CNT_BITS-1:0]           rd_cnt;
  logic [NUM_WB-1:0]             release_v;
  logic [NW_BITS-1:0]            wb_wid [NUM_WB];
  logic [NR_BITS-1:0]            wb_rd  [NUM_WB];

  function automatic logic src_blocks(input logic [CNT_BITS-1:0] c, input logic [NR_BITS-1:0] r);
    return (c != '0) && !((R0_HARDWIRED != 0) && (r == '0));
  endfunction

  genvar gi, gj, gk;

  generate
    for (gi = 0; gi < NUM_WB; gi++) begin : g_wb
      assign wb_wid[gi]    = writeback_if_wid[gi*NW_BITS +: NW_BITS];
      assign wb_rd[gi]     = writeback_if_rd[gi*NR_BITS +: NR_BITS];
      assign release_v[gi] = writeback_if_valid[gi] && writeback_if_eop[gi] &&
                             !((R0_HARDWIRED != 0) && (wb_rd[gi] == '0));
    end
  endgenerate

  assign raw_block = src_blocks(cnt_q[ibuffer_if_wid][ibuffer_if_rs1], ibuffer_if_rs1) ||
                     src_blocks(cnt_q[ibuffer_if_wid][ibuffer_if_rs2], ibuffer_if_rs2) ||
                     src_blocks(cnt_q[ibuffer_if_wid][ibuffer_if_rs3], ibuffer_if_rs3);

  assign rd_cnt    = cnt_q[ibuffer_if_wid][ibuffer_if_rd];
  assign rd_live   = ibuffer_if_wb && !((R0_HARDWIRED != 0) && (ibuffer_if_rd == '0));
  assign waw_block = rd_live && ((WAW_STALL != 0) ? (rd_cnt != '0) : (rd_cnt == CMAX));

  assign ibuffer_if_ready   = !(raw_block || waw_block);
  assign reserve            = ibuffer_if_valid && ibuffer_if_ready && rd_live;
  assign writeback_if_ready = '1;
  assign underflow_err      = underflow_q;

  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      logic [NUM_REGS-1:0] nz;
      for (gj = 0; gj < NUM_REGS; gj++) begin : g_reg
        logic              inc;
        logic [NUM_WB-1:0] hit;
        logic [EW-1:0]     sum;
        logic [EW-1:0]     dec;

        assign inc = reserve && (ibuffer_if_wid == NW_BITS'(gi)) && (ibuffer_if_rd == NR_BITS'(gj));
        for (gk = 0; gk < NUM_WB; gk++) begin : g_hit
          assign hit[gk] = release_v[gk] && (wb_wid[gk] == NW_BITS'(gi)) && (wb_rd[gk] == NR_BITS'(gj));
        end

        // Each releasing channel counts separately; excess releases clamp at zero.
        assign sum                       = EW'(cnt_q[gi][gj]) + EW'(inc);
        assign dec                       = EW'($countones(hit));
        assign uf_vec[gi*NUM_REGS + gj]  = (dec > sum);
        assign cnt_d[gi][gj]             = (dec > sum) ? '0 : CNT_BITS'(sum - dec);
        assign nz[gj]                    = (cnt_q[gi][gj] != '0);
      end
      assign warp_busy[gi] = |nz;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          cnt_q[w][r] <= '0;
        end
      end
      underflow_q <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          cnt_q[w][r] <= cnt_d[w][r];
        end
      end
      underflow_q <= underflow_q | (|uf_vec);
    end
  end

endmodule

// File: tb/tb_rv_scoreboard_mc.sv
// Scoreboard bench: two DUT variants (WAW stall / hardwired-r0 with counting WAW) share stimulus;
// a spec-level counter model predicts outputs, a negedge monitor pops and compares.
module tb_rv_scoreboard_mc;

  localparam int CMAX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        ib_valid;
  logic [1:0]  ib_wid;
  logic        ib_wb;
  logic [5:0]  ib_rd, ib_rs1, ib_rs2, ib_rs3;
  logic [1:0]  wb_valid, wb_eop;
  logic [3:0]  wb_wid;
  logic [11:0] wb_rd;

  logic        rdy_a, rdy_b, uf_a, uf_b;
  logic [3:0]  busy_a, busy_b;
  logic [1:0]  wbr_a, wbr_b;

  always #5 clk = ~clk;

  rv_scoreboard_mc #(.WAW_STALL(1), .R0_HARDWIRED(0)) dut_a (
    .clk(clk), .reset(reset),
    .ibuffer_if_valid(ib_valid), .ibuffer_if_wid(ib_wid), .ibuffer_if_wb(ib_wb),
    .ibuffer_if_rd(ib_rd), .ibuffer_if_rs1(ib_rs1), .ibuffer_if_rs2(ib_rs2), .ibuffer_if_rs3(ib_rs3),
    .ibuffer_if_ready(rdy_a),
    .writeback_if_valid(wb_valid), .writeback_if_wid(wb_wid), .writeback_if_rd(wb_rd),
    .writeback_if_eop(wb_eop), .writeback_if_ready(wbr_a),
    .warp_busy(busy_a), .underflow_err(uf_a)
  );

  rv_scoreboard_mc #(.WAW_STALL(0), .R0_HARDWIRED(1)) dut_b (
    .clk(clk), .reset(reset),
    .ibuffer_if_valid(ib_valid), .ibuffer_if_wid(ib_wid), .ibuffer_if_wb(ib_wb),
    .ibuffer_if_rd(ib_rd), .ibuffer_if_rs1(ib_rs1), .ibuffer_if_rs2(ib_rs2), .ibuffer_if_rs3(ib_rs3),
    .ibuffer_if_ready(rdy_b),
    .writeback_if_valid(wb_valid), .writeback_if_wid(wb_wid), .writeback_if_rd(wb_rd),
    .writeback_if_eop(wb_eop), .writeback_if_ready(wbr_b),
    .warp_busy(busy_b), .underflow_err(uf_b)
  );

  typedef struct packed {
    logic       rdy;
    logic [3:0] busy;
    logic       uf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int  n_cmp = 0;
  int  n_mis = 0;

  // Reference state: pending writes per instance/warp/register.
  int  mcnt [2][4][64];
  bit  muf  [2];
  bit  mrdy [2];
  bit  m_waw[2];
  bit  m_r0 [2];
  bit  upd_en = 1'b0;

  task automatic chk(input string nm, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, expv, $time);
    end
  endtask

  function automatic bit model_ready(input int i);
    int  w;
    int  srcs[3];
    bit  blk;
    w       = int'(ib_wid);
    srcs[0] = int'(ib_rs1);
    srcs[1] = int'(ib_rs2);
    srcs[2] = int'(ib_rs3);
    blk     = 1'b0;
    foreach (srcs[s]) begin
      if (mcnt[i][w][srcs[s]] > 0 && !(m_r0[i] && srcs[s] == 0)) blk = 1'b1;
    end
    if (ib_wb && !(m_r0[i] && ib_rd == 0)) begin
      if (m_waw[i] ? (mcnt[i][w][ib_rd] > 0) : (mcnt[i][w][ib_rd] >= CMAX)) blk = 1'b1;
    end
    return !blk;
  endfunction

  function automatic logic [3:0] model_busy(input int i);
    logic [3:0] b;
    b = '0;
    for (int w = 0; w < 4; w++)
      for (int r = 0; r < 64; r++)
        if (mcnt[i][w][r] > 0) b[w] = 1'b1;
    return b;
  endfunction

  task automatic model_update();
    int w, r;
    for (int i = 0; i < 2; i++) begin
      if (ib_valid && mrdy[i] && ib_wb && !(m_r0[i] && ib_rd == 0))
        mcnt[i][ib_wid][ib_rd] = mcnt[i][ib_wid][ib_rd] + 1;
      for (int k = 0; k < 2; k++) begin
        w = int'(wb_wid[k*2 +: 2]);
        r = int'(wb_rd[k*6 +: 6]);
        if (wb_valid[k] && wb_eop[k] && !(m_r0[i] && r == 0))
          mcnt[i][w][r] = mcnt[i][w][r] - 1;
      end
      for (int k = 0; k < 2; k++) begin
        w = int'(wb_wid[k*2 +: 2]);
        r = int'(wb_rd[k*6 +: 6]);
        if (mcnt[i][w][r] < 0) begin
          mcnt[i][w][r] = 0;
          muf[i]        = 1'b1;
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      muf[i] = 1'b0;
      for (int w = 0; w < 4; w++)
        for (int r = 0; r < 64; r++)
          mcnt[i][w][r] = 0;
    end
  endtask

  task automatic set_idle();
    ib_valid = 0; ib_wid = 0; ib_wb = 0; ib_rd = 0; ib_rs1 = 0; ib_rs2 = 0; ib_rs3 = 0;
    wb_valid = 0; wb_eop = 0; wb_wid = 0; wb_rd = 0;
  endtask

  task automatic step(input bit v, input int wid, input bit wb, input int rd,
                      input int s1, input int s2, input int s3,
                      input bit [1:0] wv, input int w0, input int d0,
                      input int w1, input int d1, input bit [1:0] eop);
    exp_t e;
    @(posedge clk);
    if (upd_en) model_update();
    #1;
    ib_valid = v;  ib_wid = 2'(wid); ib_wb = wb; ib_rd = 6'(rd);
    ib_rs1 = 6'(s1); ib_rs2 = 6'(s2); ib_rs3 = 6'(s3);
    wb_valid = wv; wb_eop = eop;
    wb_wid = {2'(w1), 2'(w0)};
    wb_rd  = {6'(d1), 6'(d0)};
    upd_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mrdy[i] = model_ready(i);
      e.rdy   = mrdy[i];
      e.busy  = model_busy(i);
      e.uf    = muf[i];
      if (i == 0) q_a.push_back(e); else q_b.push_back(e);
    end
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_rdy_a", rdy_a, 1);   chk("rst_rdy_b", rdy_b, 1);
    chk("rst_busy_a", busy_a, 0); chk("rst_busy_b", busy_b, 0);
    chk("rst_uf_a", uf_a, 0);     chk("rst_uf_b", uf_b, 0);
    chk("rst_wbr_a", wbr_a, 3);   chk("rst_wbr_b", wbr_b, 3);
    set_idle();
    model_clear();
    upd_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: one expectation per cycle per instance, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("mon_rdy_a", rdy_a, e.rdy);
      chk("mon_busy_a", busy_a, e.busy);
      chk("mon_uf_a", uf_a, e.uf);
      chk("mon_wbr_a", wbr_a, 3);
      $display("cyc a: rdy=%0d busy=%b uf=%0d", rdy_a, busy_a, uf_a);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("mon_rdy_b", rdy_b, e.rdy);
      chk("mon_busy_b", busy_b, e.busy);
      chk("mon_uf_b", uf_b, e.uf);
      chk("mon_wbr_b", wbr_b, 3);
      $display("cyc b: rdy=%0d busy=%b uf=%0d", rdy_b, busy_b, uf_b);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_waw[0] = 1'b1; m_r0[0] = 1'b0;
    m_waw[1] = 1'b0; m_r0[1] = 1'b1;
    model_clear();
    mrdy[0] = 1'b1; mrdy[1] = 1'b1;
    reset = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    do_reset();

    // RAW hazard and one-cycle release latency.
    step(1, 1, 1, 5, 10, 11, 12, 2'b00, 0, 0, 0, 0, 2'b00);
    #1 chk("issue_rdy_a", rdy_a, 1);
    step(1, 1, 0, 0, 0, 5, 0, 2'b00, 0, 0, 0, 0, 2'b00);
    #1 chk("raw_rdy_a", rdy_a, 0); chk("raw_rdy_b", rdy_b, 0); chk("raw_busy_a", busy_a, 4'b0010);
    step(1, 1, 0, 0, 0, 5, 0, 2'b00, 0, 0, 0, 0, 2'b00);
    step(1, 1, 0, 0, 0, 5, 0, 2'b10, 0, 0, 1, 5, 2'b10);
    #1 chk("rel_same_cyc_rdy_a", rdy_a, 0); chk("rel_same_cyc_busy_a", busy_a, 4'b0010);
    step(1, 1, 0, 0, 0, 5, 0, 2'b00, 0, 0, 0, 0, 2'b00);
    #1 chk("rel_next_rdy_a", rdy_a, 1); chk("rel_next_busy_a", busy_a, 0);

    // Counting WAW (instance b) saturates at CMAX.
    repeat (4) step(1, 0, 1, 7, 1, 2, 3, 2'b00, 0, 0, 0, 0, 2'b00);
    #1 chk("waw_full_rdy_b", rdy_b, 0); chk("waw_stall_rdy_a", rdy_a, 0);
    step(1, 0, 1, 7, 1, 2, 3, 2'b01, 0, 7, 0, 0, 2'b01);
    #1 chk("waw_rel_cyc_rdy_b", rdy_b, 0);
    step(1, 0, 1, 7, 1, 2, 3, 2'b00, 0, 0, 0, 0, 2'b00);
    #1 chk("waw_after_rel_rdy_b", rdy_b, 1);
    idle_step();

    // Reserve and release on the same register net to zero.
    step(1, 2, 1, 9, 1, 2, 3, 2'b00, 0, 0, 0, 0, 2'b00);
    step(1, 2, 1, 9, 1, 2, 3, 2'b01, 2, 9, 0, 0, 2'b01);
    #1 chk("net_zero_rdy_b", rdy_b, 1);
    step(1, 2, 0, 0, 9, 1, 2, 2'b00, 0, 0, 0, 0, 2'b00);
    #1 chk("net_zero_blk_b", rdy_b, 0); chk("net_zero_free_a", rdy_a, 1);
    idle_step();

    // Double release underflows and sticks.
    step(1, 0, 1, 3, 20, 21, 22, 2'b00, 0, 0, 0, 0, 2'b00);
    step(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 3, 0, 3, 2'b11);
    #1 chk("uf_pre_a", uf_a, 0);
    idle_step();
    #1 chk("uf_set_a", uf_a, 1); chk("uf_set_b", uf_b, 1);
    idle_step();
    #1 chk("uf_hold_a", uf_a, 1);

    // Register 0 hardwired in instance b.
    step(1, 3, 1, 0, 30, 31, 32, 2'b00, 0, 0, 0, 0, 2'b00);
    step(1, 3, 0, 0, 0, 30, 31, 2'b00, 0, 0, 0, 0, 2'b00);
    #1 chk("r0_rdy_b", rdy_b, 1); chk("r0_busy_b", busy_b, 4'b0101); chk("r0_rdy_a", rdy_a, 0);
    do_reset();

    // Randomised rounds separated by asynchronous resets.
    for (int rnd = 0; rnd < 6; rnd++) begin
      repeat (200) begin
        step(($urandom % 4) != 0, int'($urandom % 4), 1'($urandom % 2), int'($urandom % 8),
             int'($urandom % 8), int'($urandom % 8), int'($urandom % 8),
             {1'(($urandom % 3) == 0), 1'(($urandom % 3) == 0)},
             int'($urandom % 4), int'($urandom % 8), int'($urandom % 4), int'($urandom % 8),
             {1'(($urandom % 3) != 0), 1'(($urandom % 3) != 0)});
      end
      do_reset();
    end

    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain: got %0d pending expected 0", q_a.size() + q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rv_scoreboard_mc.md
Name: rv_scoreboard_mc

Overview:
- Per-warp register hazard tracker for the issue stage; successor to the single-bit in-use scoreboard.
- Sits between the ibuffer and the operand collector/dispatch.
- Generalised to NUM_WB writeback channels and a per-register pending-write counter instead of a single in-use bit.
- Adds a configurable WAW policy, optional hardwired register 0, per-warp busy flags and a sticky underflow error.

Parameters:
- NUM_WARPS, 4, number of warps tracked.
- NW_BITS, 2, warp id width (clog2 NUM_WARPS, minimum 1).
- NUM_REGS, 64, registers per warp (integer + FP).
- NR_BITS, 6, register index width.
- NUM_WB, 2, independent writeback channels.
- CNT_BITS, 2, pending-write counter width; CMAX = 2^CNT_BITS-1.
- WAW_STALL, 1, 1: rd with pending write blocks issue; 0: rd blocks only when its counter equals CMAX.
- R0_HARDWIRED, 0, 1: register index 0 is never reserved, released or blocking.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ibuffer_if_valid  in  1  instruction at ibuffer head
- ibuffer_if_wid  in  NW_BITS  warp of head instruction
- ibuffer_if_wb  in  1  head instruction writes rd
- ibuffer_if_rd  in  NR_BITS  destination register
- ibuffer_if_rs1  in  NR_BITS  source register 1
- ibuffer_if_rs2  in  NR_BITS  source register 2
- ibuffer_if_rs3  in  NR_BITS  source register 3
- ibuffer_if_ready  out  1  head may issue
- writeback_if_valid  in  NUM_WB  per-channel valid
- writeback_if_wid  in  NUM_WB*NW_BITS  per-channel warp, channel k at [k*NW_BITS +: NW_BITS]
- writeback_if_rd  in  NUM_WB*NR_BITS  per-channel rd
- writeback_if_eop  in  NUM_WB  last packet of this writeback
- writeback_if_ready  out  NUM_WB  per-channel ready
- warp_busy  out  NUM_WARPS  bit w = any counter of warp w non-zero
- underflow_err  out  1  sticky release-at-zero flag

Behaviour:
- State: cnt[w][r], CNT_BITS wide, for every warp and register; plus the underflow_err flip-flop.
- Reset (reset=0, asynchronous): all cnt = 0, underflow_err = 0. Outputs after reset: ibuffer_if_ready = 1, warp_busy = 0, writeback_if_ready = all ones.
- writeback_if_ready is constant all ones; writebacks are never back-pressured.
- ibuffer_if_ready is combinational from registered cnt only; it does not depend on ibuffer_if_valid. It is 0 when any of these hold:
  - cnt[wid][rs1], cnt[wid][rs2] or cnt[wid][rs3] is non-zero.
  - ibuffer_if_wb=1 and WAW_STALL=1 and cnt[wid][rd] is non-zero.
  - ibuffer_if_wb=1 and WAW_STALL=0 and cnt[wid][rd] == CMAX.
- When R0_HARDWIRED=1, any operand equal to 0 never blocks.
- A release in cycle t does not unblock in cycle t; ready rises in cycle t+1. Latency from release to ready is 1 cycle.
- reserve = valid & ready & wb, and rd is not register 0 when R0_HARDWIRED=1.
- release_k = writeback_if_valid[k] & writeback_if_eop[k], same register-0 exclusion. Non-eop packets have no effect.
- Next-state per [w][r]: cnt + (reserve hits [w][r]) - (number of release channels hitting [w][r]).
- Multiple channels releasing the same register in the same cycle each count separately.
- A reserve and a release on the same register in the same cycle net to zero change.
- If the total decrement exceeds cnt + inc:
  - cnt clamps to 0.
  - underflow_err is set on the next edge and stays set until reset.
- Overflow cannot occur: the ready rule prevents a reserve when cnt == CMAX.
- warp_busy is registered-derived: the OR-reduction of the current cnt, with no same-cycle lookahead.
- Reset asserted mid-operation clears all state immediately. Any writeback arriving afterwards for an old reservation underflows and raises underflow_err; flushing in-flight writebacks is the system's responsibility.

Test Plan:
- Reset, then idle → ibuffer_if_ready=1, warp_busy=0000, underflow_err=0.
- Issue wid=1 rd=5 wb=1 (cycle 0). Next cycle, head wid=1 rs2=5 → ready=0. Writeback ch1 wid=1 rd=5 eop=1 at cycle 3 → ready stays 0 at cycle 3, becomes 1 at cycle 4. warp_busy[1] goes 0→1→0.
- WAW_STALL=0, CNT_BITS=2: issue wid=0 rd=7 three times back-to-back → cnt=3. Fourth issue rd=7 → ready=0. One eop release → fourth issue accepted the next cycle.
- Same cycle: reserve wid=2 rd=9 and release wid=2 rd=9 on ch0 with cnt=1 → cnt stays 1; rs1=9 remains blocked.
- cnt[0][3]=1; ch0 and ch1 both release wid=0 rd=3 eop=1 → cnt=0 and underflow_err=1 on the next edge, held until reset.
- R0_HARDWIRED=1: issue rd=0 wb=1, then head rs1=0 → ready=1, warp_busy unchanged. Assert reset low mid-sequence with cnt non-zero → all cleared asynchronously, ready=1.
